// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter (8 data bits, LSB first, optional parity,
// one or two stop bits). A one-entry holding register takes the next byte
// while a frame is on the line, so consecutive frames leave no idle gap.
//
// Parameters
//   UART_BPS    baud rate
//   CLK_FREQ    sys_clk frequency in Hz; one bit lasts CLK_FREQ/UART_BPS cycles
//   PARITY_EN   1: a parity bit follows data bit 7
//   PARITY_ODD  0: even parity (^data), 1: odd parity (~^data)
//   STOP_BITS   1 or 2
//
// Ports
//   sys_clk    in   system clock, all logic on posedge
//   sys_rst_n  in   asynchronous reset, active low
//   pi_flag    in   one-cycle strobe, pi_data valid
//   pi_data    in   [7:0] byte to send
//   tx         out  serial line, idle high, registered
//   tx_busy    out  high while a frame (start .. last stop) is on the line
//   tx_ready   out  high while the holding register is empty
//   tx_done    out  one-cycle pulse in the last cycle of the final stop bit
//   fsm_state  out  [2:0] current FSM state (IDLE=0 START=1 DATA=2 PARITY=3
//                   STOP=4), for debug and checkers
//
// Handshake: a byte is taken on every posedge where pi_flag && tx_ready.
// When tx_ready is low a strobe is dropped with no effect; pi_data is only
// looked at when pi_flag is high.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int UART_BPS   = 'd9600,
  parameter int CLK_FREQ   = 'd50_000_000,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [2:0] fsm_state
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  // Index of the final stop bit in stop_cnt (stop_cnt only ever counts 0..1).
  localparam logic        STOP_LAST    = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q, tx_d;

  logic baud_end;
  logic last_stop;
  logic frame_end;
  logic accept;

  function automatic logic calc_parity(input logic [7:0] d);
    return PARITY_ODD ? ~^d : ^d;
  endfunction

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  assign last_stop = (stop_cnt_q == STOP_LAST);
  assign frame_end = (state_q == S_STOP) && baud_end && last_stop;
  assign accept    = pi_flag && !hold_full_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. tx_d is the line level for the state being entered, so
  // tx changes on the same edge as the state and never glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;

    // The baud counter runs only inside a frame and wraps at the end of every
    // bit, so a back-to-back start bit begins with a fresh count.
    if (state_q == S_IDLE || baud_end) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = pi_data;
          par_d   = calc_parity(pi_data);
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = S_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            // shift_q[0] is always the bit currently on the line.
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          if (last_stop) begin
            if (hold_full_q) begin
              // Queued byte goes straight out; the line never returns idle.
              shift_d     = hold_q;
              par_d       = calc_parity(hold_q);
              hold_full_d = 1'b0;
              state_d     = S_START;
              tx_d        = 1'b0;
            end else if (accept) begin
              // A strobe landing on the very last cycle bypasses the holding
              // register for the same no-gap result.
              shift_d = pi_data;
              par_d   = calc_parity(pi_data);
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Mid-frame strobe: park the byte until the current frame ends.
    if (accept && (state_q != S_IDLE) && !frame_end) begin
      hold_d      = pi_data;
      hold_full_d = 1'b1;
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_ready  = !hold_full_q;
  assign tx_done   = frame_end;
  assign fsm_state = state_q;

endmodule
